// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared EX-stage encodings: RV32M ops, mul/div FSM states, MEM opcodes
package ex_muldiv_pkg;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'd0,
      MULDIV_MULH   = 3'd1,
      MULDIV_MULHSU = 3'd2,
      MULDIV_MULHU  = 3'd3,
      MULDIV_DIV    = 3'd4,
      MULDIV_DIVU   = 3'd5,
      MULDIV_REM    = 3'd6,
      MULDIV_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MULDIV_ST_IDLE = 2'd0,
      MULDIV_ST_MUL  = 2'd1,
      MULDIV_ST_DIV  = 2'd2,
      MULDIV_ST_DONE = 2'd3
   } muldiv_state_e;

   typedef enum logic [2:0] {
      MEM_LB  = 3'd0,
      MEM_LH  = 3'd1,
      MEM_LW  = 3'd2,
      MEM_LBU = 3'd4,
      MEM_LHU = 3'd5
   } mem_load_e;

   typedef enum logic [1:0] {
      MEM_SB = 2'd0,
      MEM_SH = 2'd1,
      MEM_SW = 2'd2
   } mem_store_e;

   localparam int MULDIV_STEPS = 32;

   function automatic logic [31:0] muldiv_mag(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit with a shared 64-bit accumulator
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] rs1_i,
   input  logic [DATA_WIDTH-1:0] rs2_i,
   input  logic [4:0]            rd_add_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [4:0]            rd_add_o
);

   localparam int W = DATA_WIDTH;

   muldiv_state_e  state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   b_q, b_d;
   muldiv_op_e     op_q, op_d;
   logic           sign1_q, sign1_d;
   logic           sign2_q, sign2_d;
   logic [4:0]     rd_q, rd_d;
   logic [W-1:0]   result_q, result_d;
   logic [4:0]     rd_out_q, rd_out_d;

   muldiv_op_e     op_in;
   logic           a_signed, b_signed, in_s1, in_s2;
   logic           div_zero, div_ovf;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_sh, div_diff;
   logic           div_qbit;
   logic [2*W-1:0] div_next;

   // Product is negated as a whole; quotient and remainder carry independent signs.
   function automatic logic [W-1:0] fixup(input muldiv_op_e op, input logic s1,
                                          input logic s2, input logic [2*W-1:0] f);
      logic [2*W-1:0] prod;
      logic [W-1:0]   quo, rem;
      prod = (s1 ^ s2) ? (~f + (2*W)'(1)) : f;
      quo  = (s1 ^ s2) ? (~f[W-1:0] + W'(1)) : f[W-1:0];
      rem  = s1 ? (~f[2*W-1:W] + W'(1)) : f[2*W-1:W];
      case (op)
         MULDIV_MUL:               return prod[W-1:0];
         MULDIV_MULH, MULDIV_MULHSU,
         MULDIV_MULHU:             return prod[2*W-1:W];
         MULDIV_DIV, MULDIV_DIVU:  return quo;
         default:                  return rem;
      endcase
   endfunction

   always_comb begin
      op_in    = muldiv_op_e'(op_i);
      a_signed = op_in inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
      b_signed = op_in inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
      in_s1    = a_signed & rs1_i[W-1];
      in_s2    = b_signed & rs2_i[W-1];
      div_zero = op_i[2] && (rs2_i == '0);
      div_ovf  = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(W-1){1'b0}}}) && (rs2_i == '1);
   end

   // One shift-add step: upper half accumulates, multiplier bits shift out the bottom.
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   // One restoring step: shifted remainder minus divisor; borrow means restore.
   assign div_sh   = acc_q[2*W-1:W-1];
   assign div_diff = div_sh - {1'b0, b_q};
   assign div_qbit = ~div_diff[W];
   assign div_next = {(div_qbit ? div_diff[W-1:0] : div_sh[W-1:0]), acc_q[W-2:0], div_qbit};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      op_d     = op_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      rd_d     = rd_q;
      result_d = result_q;
      rd_out_d = rd_out_q;

      case (state_q)
         MULDIV_ST_IDLE: begin
            if (valid_i) begin
               op_d    = op_in;
               rd_d    = rd_add_i;
               sign1_d = in_s1;
               sign2_d = in_s2;
               acc_d   = {{W{1'b0}}, muldiv_mag(rs1_i, in_s1)};
               b_d     = muldiv_mag(rs2_i, in_s2);
               cnt_d   = '0;
               if (div_zero) begin
                  result_d = op_i[1] ? rs1_i : '1;
                  rd_out_d = rd_add_i;
                  state_d  = MULDIV_ST_DONE;
               end else if (div_ovf) begin
                  result_d = op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                  rd_out_d = rd_add_i;
                  state_d  = MULDIV_ST_DONE;
               end else begin
                  state_d = op_i[2] ? MULDIV_ST_DIV : MULDIV_ST_MUL;
               end
            end
         end
         MULDIV_ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MULDIV_STEPS - 1)) begin
               cnt_d    = '0;
               result_d = fixup(op_q, sign1_q, sign2_q, mul_next);
               rd_out_d = rd_q;
               state_d  = MULDIV_ST_DONE;
            end
         end
         MULDIV_ST_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MULDIV_STEPS - 1)) begin
               cnt_d    = '0;
               result_d = fixup(op_q, sign1_q, sign2_q, div_next);
               rd_out_d = rd_q;
               state_d  = MULDIV_ST_DONE;
            end
         end
         default: state_d = MULDIV_ST_IDLE;
      endcase

      // Squash wins over everything, including a same-cycle request or completion.
      if (flush_i) begin
         state_d  = MULDIV_ST_IDLE;
         cnt_d    = '0;
         acc_d    = acc_q;
         b_d      = b_q;
         op_d     = op_q;
         sign1_d  = sign1_q;
         sign2_d  = sign2_q;
         rd_d     = rd_q;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MULDIV_ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         op_q     <= MULDIV_MUL;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         op_q     <= op_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busy_o   = (state_q == MULDIV_ST_MUL) || (state_q == MULDIV_ST_DIV);
   assign done_o   = (state_q == MULDIV_ST_DONE);
   assign result_o = result_q;
   assign rd_add_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed vector bench for ex_muldiv
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic [4:0]  rd_add_i = '0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_add_o;

   int checks = 0;
   int errors = 0;

   ex_muldiv #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_add_i(rd_add_i), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .rd_add_o(rd_add_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_add_i = rd;
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   task automatic wait_done(input int max, output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int k = 1; k <= max; k++) begin
         @(negedge clk);
         if (done_o) begin
            lat = k;
            break;
         end
         if (busy_o) busy_cnt++;
      end
   endtask

   task automatic add(input string n, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input int lat);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
      vecs.push_back(v);
   endtask

   initial begin
      int lat, bc;
      logic [4:0] rd;

      add("mul_7x6",        3'd0, 32'd7,        32'd6,        32'd42,       33);
      add("mulh_m1xm1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
      add("mulhu_m1xm1",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      add("mulhsu_m1x2",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
      add("mul_m3x5",       3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
      add("mulh_min_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      add("mulhu_min_x4",   3'd3, 32'h80000000, 32'd4,        32'h00000002, 33);
      add("div_m7_2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      add("rem_m7_2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      add("divu_100_7",     3'd5, 32'd100,      32'd7,        32'd14,       33);
      add("remu_100_7",     3'd7, 32'd100,      32'd7,        32'd2,        33);
      add("div_7_m2",       3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      add("rem_7_m2",       3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
      add("divu_max_1",     3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
      add("div_5_0",        3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      add("rem_5_0",        3'd6, 32'd5,        32'd0,        32'd5,        1);
      add("divu_5_0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      add("div_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      add("rem_ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      #3;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_rd", 32'(rd_add_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         rd = 5'(i + 1);
         start(vecs[i].op, vecs[i].a, vecs[i].b, rd);
         wait_done(40, lat, bc);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
         check({vecs[i].name, "_busycycles"}, 32'(bc), 32'(vecs[i].lat - 1));
         check({vecs[i].name, "_busy_in_done"}, 32'(busy_o), 32'd0);
         check({vecs[i].name, "_result"}, result_o, vecs[i].res);
         check({vecs[i].name, "_rd"}, 32'(rd_add_o), 32'(rd));
         @(negedge clk);
         check({vecs[i].name, "_done_1cyc"}, 32'(done_o), 32'd0);
         check({vecs[i].name, "_hold"}, result_o, vecs[i].res);
      end

      // Flush in cycle 10 of a DIV, then MUL 3x3 accepted in cycle 11; a request during busy is ignored.
      start(3'd4, 32'd100, 32'd7, 5'd9);
      repeat (10) @(negedge clk);
      check("flush_busy_before", 32'(busy_o), 32'd1);
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", 32'(busy_o), 32'd0);
      check("flush_idle_done", 32'(done_o), 32'd0);
      valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; rd_add_i = 5'd3;
      @(posedge clk);
      #1 valid_i = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 5) begin
            valid_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1; rs2_i = 32'd0; rd_add_i = 5'd31;
         end else begin
            valid_i = 1'b0;
         end
         if (done_o) begin
            lat = k;
            break;
         end
      end
      valid_i = 1'b0;
      check("flush_mul_lat", 32'(lat), 32'd33);
      check("flush_mul_result", result_o, 32'd9);
      check("flush_mul_rd", 32'(rd_add_o), 32'd3);

      // Flush and valid together in IDLE: nothing is accepted.
      @(negedge clk);
      flush_i = 1'b1; valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2; rd_add_i = 5'd4;
      @(posedge clk);
      #1 begin flush_i = 1'b0; valid_i = 1'b0; end
      wait_done(40, lat, bc);
      check("prio_no_done", 32'(lat), 32'hFFFFFFFF);
      check("prio_no_busy", 32'(bc), 32'd0);
      check("prio_result_held", result_o, 32'd9);

      // Reset at cycle 15 of a MUL, released at cycle 20.
      start(3'd0, 32'd5, 32'd5, 5'd7);
      repeat (14) @(negedge clk);
      check("rstmid_busy_before", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", 32'(busy_o), 32'd0);
      check("rstmid_done", 32'(done_o), 32'd0);
      check("rstmid_result", result_o, 32'd0);
      check("rstmid_rd", 32'(rd_add_o), 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      wait_done(40, lat, bc);
      check("rstmid_no_done", 32'(lat), 32'hFFFFFFFF);
      check("rstmid_no_busy", 32'(bc), 32'd0);
      check("rstmid_result_after", result_o, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
